// File: rtl/oam_dma_controller.sv
// OAM DMA sequencer: copies NUM_BYTES bytes from page {page_eff,8'h00} into OAM,
// one byte per BYTE_CYCLES clocks, with every output driven from a register.
module oam_dma_controller #(
    parameter int NUM_BYTES    = 160,
    parameter int BYTE_CYCLES  = 4,
    parameter int READ_LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dma_start,
    input  logic [7:0]  dma_page,
    output logic [15:0] src_address,
    output logic        src_oe,
    input  logic [7:0]  src_data,
    output logic [7:0]  oam_address,
    output logic [7:0]  oam_data,
    output logic        oam_we,
    output logic        active,
    output logic        done
);

    localparam int SW = (BYTE_CYCLES > 2) ? $clog2(BYTE_CYCLES) : 1;
    localparam logic [SW-1:0] LAST_SLOT = SW'(BYTE_CYCLES - 1);
    localparam logic [SW-1:0] PRE_SLOT  = SW'(BYTE_CYCLES - 2);
    localparam logic [SW-1:0] SMP_SLOT  = SW'(READ_LATENCY);
    localparam logic [7:0]    LAST_IDX  = 8'(NUM_BYTES - 1);

    typedef enum logic [1:0] {IDLE, START, XFER} state_t;

    state_t        state_q;
    logic [7:0]    index_q;
    logic [SW-1:0] slot_q;
    logic [7:0]    page_q;
    logic [15:0]   src_address_q;
    logic          src_oe_q;
    logic [7:0]    oam_address_q;
    logic [7:0]    oam_data_q;
    logic          oam_we_q;
    logic          active_q;
    logic          done_q;

    logic [7:0]    page_d;
    logic [7:0]    index_inc;

    // Pages 0xE0-0xFF alias the work RAM echo region.
    assign page_d    = (dma_page < 8'hE0) ? dma_page : (dma_page & 8'hDF);
    assign index_inc = index_q + 8'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            index_q       <= '0;
            slot_q        <= '0;
            page_q        <= '0;
            src_address_q <= '0;
            src_oe_q      <= 1'b0;
            oam_address_q <= '0;
            oam_data_q    <= '0;
            oam_we_q      <= 1'b0;
            active_q      <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            done_q   <= 1'b0;
            oam_we_q <= 1'b0;
            if (dma_start) begin
                // A start while busy abandons the current copy without a done pulse.
                state_q       <= START;
                page_q        <= page_d;
                index_q       <= '0;
                slot_q        <= '0;
                active_q      <= 1'b1;
                src_oe_q      <= 1'b0;
                src_address_q <= '0;
                oam_address_q <= '0;
                oam_data_q    <= '0;
            end else begin
                case (state_q)
                    START: begin
                        state_q       <= XFER;
                        index_q       <= '0;
                        slot_q        <= '0;
                        src_oe_q      <= 1'b1;
                        src_address_q <= {page_q, 8'h00};
                        oam_address_q <= '0;
                    end
                    XFER: begin
                        // src_data is captured in the first slot it is valid, and the
                        // write strobe is raised so it lands in the byte's last slot.
                        if (slot_q == SMP_SLOT) oam_data_q <= src_data;
                        oam_we_q <= (slot_q == PRE_SLOT);
                        if (slot_q == LAST_SLOT) begin
                            slot_q <= '0;
                            if (index_q == LAST_IDX) begin
                                state_q       <= IDLE;
                                index_q       <= '0;
                                active_q      <= 1'b0;
                                done_q        <= 1'b1;
                                src_oe_q      <= 1'b0;
                                src_address_q <= '0;
                                oam_address_q <= '0;
                                oam_data_q    <= '0;
                            end else begin
                                index_q       <= index_inc;
                                src_address_q <= {page_q, index_inc};
                                oam_address_q <= index_inc;
                            end
                        end else begin
                            slot_q <= slot_q + 1'b1;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign src_address = src_address_q;
    assign src_oe      = src_oe_q;
    assign oam_address = oam_address_q;
    assign oam_data    = oam_data_q;
    assign oam_we      = oam_we_q;
    assign active      = active_q;
    assign done        = done_q;

endmodule
